// File: rtl/elevator_car_controller.sv
// Elevator car controller: drives motor and door for one car serving floors 0..6.
// The car idles, travels floor by floor, and opens the door at requested floors.
//
// Ports:
//   clk              rising-edge clock
//   rst              synchronous active-high reset
//   queue_status     pending-call bitmap, bit n = floor n requested
//   queue_empty      no calls pending (from the direction resolver)
//   next_up_ndown    recommended direction from the resolver, 1 = up
//   current_floor    registered car position 0..6
//   current_up_ndown registered committed travel direction
//   motor_en         registered, high while the car is moving
//   motor_up_ndown   registered motor direction, tracks current_up_ndown
//   door_open        registered, high while the door is open
//   clear_req        registered one-hot pulse clearing the served floor's call
module elevator_car_controller #(
  parameter int unsigned FLOOR_TRAVEL_CYCLES = 16,
  parameter int unsigned DOOR_OPEN_CYCLES    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] queue_status,
  input  logic       queue_empty,
  input  logic       next_up_ndown,
  output logic [2:0] current_floor,
  output logic       current_up_ndown,
  output logic       motor_en,
  output logic       motor_up_ndown,
  output logic       door_open,
  output logic [6:0] clear_req
);

  typedef enum logic [1:0] {
    IDLE,
    MOVE,
    DOOR_OPEN,
    DOOR_CLOSE
  } state_t;

  localparam logic [7:0] TRAVEL_LAST = 8'(FLOOR_TRAVEL_CYCLES - 1);
  localparam logic [7:0] DWELL_LAST  = 8'(DOOR_OPEN_CYCLES - 1);

  state_t     state;
  logic [7:0] travel_cnt;
  logic [7:0] dwell_cnt;

  logic [7:0] calls;
  logic [2:0] next_floor;
  logic       call_here;
  logic       call_next;
  logic       at_limit;

  function automatic logic [6:0] floor_onehot(input logic [2:0] f);
    logic [7:0] oh;
    oh = 8'd1 << f;
    return oh[6:0];
  endfunction

  always_comb begin
    // Padded to 8 bits so a 3-bit floor index is always in range.
    calls      = {1'b0, queue_status};
    next_floor = current_up_ndown ? current_floor + 3'd1 : current_floor - 3'd1;
    call_here  = calls[current_floor];
    call_next  = calls[next_floor];
    at_limit   = current_up_ndown ? (current_floor == 3'd6) : (current_floor == 3'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      current_floor    <= '0;
      current_up_ndown <= 1'b1;
      motor_en         <= 1'b0;
      motor_up_ndown   <= 1'b1;
      door_open        <= 1'b0;
      clear_req        <= '0;
      travel_cnt       <= '0;
      dwell_cnt        <= '0;
    end else begin
      clear_req <= '0;
      case (state)
        IDLE: begin
          if (call_here) begin
            state     <= DOOR_OPEN;
            door_open <= 1'b1;
            dwell_cnt <= '0;
            clear_req <= floor_onehot(current_floor);
          end else if (!queue_empty) begin
            state            <= MOVE;
            current_up_ndown <= next_up_ndown;
            motor_up_ndown   <= next_up_ndown;
            motor_en         <= 1'b1;
            travel_cnt       <= '0;
          end
        end

        MOVE: begin
          if (at_limit) begin
            // Nowhere to go in the committed direction: stop without moving.
            state      <= IDLE;
            motor_en   <= 1'b0;
            travel_cnt <= '0;
          end else if (travel_cnt == TRAVEL_LAST) begin
            travel_cnt    <= '0;
            current_floor <= next_floor;
            if (call_next) begin
              state     <= DOOR_OPEN;
              motor_en  <= 1'b0;
              door_open <= 1'b1;
              dwell_cnt <= '0;
              clear_req <= floor_onehot(next_floor);
            end else if (queue_empty) begin
              state    <= IDLE;
              motor_en <= 1'b0;
            end
          end else begin
            travel_cnt <= travel_cnt + 8'd1;
          end
        end

        DOOR_OPEN: begin
          // While clear_req is out, the queue has not yet dropped the bit it
          // is clearing, so the stale call is ignored for that one cycle.
          if (call_here && (clear_req == '0)) begin
            dwell_cnt <= '0;
            clear_req <= floor_onehot(current_floor);
          end else if (dwell_cnt == DWELL_LAST) begin
            state     <= DOOR_CLOSE;
            door_open <= 1'b0;
            dwell_cnt <= '0;
          end else begin
            dwell_cnt <= dwell_cnt + 8'd1;
          end
        end

        DOOR_CLOSE: begin
          if (call_here) begin
            state     <= DOOR_OPEN;
            door_open <= 1'b1;
            dwell_cnt <= '0;
            clear_req <= floor_onehot(current_floor);
          end else begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_elevator_car_controller.sv
// Testbench for elevator_car_controller. A driver acts as call queue and
// direction resolver, steps a timer-based behavioural car model each cycle and
// queues the expected outputs; a monitor compares them against the DUT.
module tb_elevator_car_controller;

  localparam int unsigned FTC = 4;
  localparam int unsigned DOC = 3;

  logic       clk;
  logic       rst;
  logic [6:0] queue_status;
  logic       queue_empty;
  logic       next_up_ndown;
  logic [2:0] current_floor;
  logic       current_up_ndown;
  logic       motor_en;
  logic       motor_up_ndown;
  logic       door_open;
  logic [6:0] clear_req;

  elevator_car_controller #(
    .FLOOR_TRAVEL_CYCLES(FTC),
    .DOOR_OPEN_CYCLES(DOC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .queue_status(queue_status),
    .queue_empty(queue_empty),
    .next_up_ndown(next_up_ndown),
    .current_floor(current_floor),
    .current_up_ndown(current_up_ndown),
    .motor_en(motor_en),
    .motor_up_ndown(motor_up_ndown),
    .door_open(door_open),
    .clear_req(clear_req)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [2:0] floor;
    logic       dir;
    logic       men;
    logic       mdir;
    logic       door;
    logic [6:0] clr;
  } obs_t;

  obs_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  // Behavioural car: position, direction and remaining-time counters.
  int         m_floor;
  bit         m_dir, m_mdir, m_moving, m_closing;
  int         m_ticks;   // cycles already spent on the current floor-to-floor hop
  int         m_door;    // door-open cycles remaining, including the present one
  logic [6:0] m_clr;

  logic [6:0] bench_q;   // pending calls as seen by the car
  logic [6:0] clr_prev;  // clear pulse of the previous cycle, applied to bench_q

  task automatic model_reset();
    m_floor = 0; m_dir = 1'b1; m_mdir = 1'b1; m_moving = 1'b0;
    m_closing = 1'b0; m_ticks = 0; m_door = 0; m_clr = '0;
  endtask

  task automatic open_door(input int f);
    logic [6:0] oh;
    oh = '0;
    oh[f] = 1'b1;
    m_door = DOC;
    m_clr  = oh;
  endtask

  task automatic model_step(input logic [6:0] qs, input bit qe, input bit nud, input bit r);
    bit hit;
    bit pulsing;
    hit     = qs[m_floor];
    pulsing = (m_clr != '0);
    m_clr   = '0;
    if (r) begin
      model_reset();
    end else if (m_door > 0) begin
      if (hit && !pulsing) open_door(m_floor);
      else if (m_door == 1) begin m_door = 0; m_closing = 1'b1; end
      else m_door = m_door - 1;
    end else if (m_closing) begin
      m_closing = 1'b0;
      if (hit) open_door(m_floor);
    end else if (m_moving) begin
      if ((m_dir && m_floor == 6) || (!m_dir && m_floor == 0)) begin
        m_moving = 1'b0;
        m_ticks  = 0;
      end else begin
        m_ticks = m_ticks + 1;
        if (m_ticks == FTC) begin
          m_ticks = 0;
          m_floor = m_dir ? m_floor + 1 : m_floor - 1;
          if (qs[m_floor]) begin m_moving = 1'b0; open_door(m_floor); end
          else if (qe) m_moving = 1'b0;
        end
      end
    end else begin
      if (hit) open_door(m_floor);
      else if (!qe) begin
        m_dir = nud; m_mdir = nud; m_moving = 1'b1; m_ticks = 0;
      end
    end
  endtask

  // One clock cycle of stimulus. frc drives the "forced up, nothing pending" inputs.
  task automatic drive(input logic [6:0] newc, input bit r, input bit frc);
    logic [6:0] cur_clr, qs_v, lower;
    bit   above, below, qe_v, nud_v;
    obs_t e;
    @(negedge clk);
    cur_clr = m_clr;
    if (r) bench_q = '0;
    else   bench_q = (bench_q & ~clr_prev) | newc;
    lower = 7'((8'd1 << m_floor) - 8'd1);
    above = (bench_q & ~lower & ~(7'd1 << m_floor)) != '0;
    below = (bench_q & lower) != '0;
    if (frc) begin
      qs_v = '0; qe_v = 1'b0; nud_v = 1'b1;
    end else begin
      qs_v  = bench_q;
      qe_v  = (bench_q == '0);
      nud_v = m_dir ? (above || !below) : (!below && above);
    end
    rst = r; queue_status = qs_v; queue_empty = qe_v; next_up_ndown = nud_v;
    model_step(qs_v, qe_v, nud_v, r);
    clr_prev = r ? '0 : cur_clr;
    e.floor = 3'(m_floor); e.dir = m_dir; e.men = m_moving; e.mdir = m_mdir;
    e.door = (m_door > 0); e.clr = m_clr;
    exp_q.push_back(e);
  endtask

  task automatic bound_fail(input string what, input int budget);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait exceeded budget of %0d cycles, required completion", what, budget);
  endtask

  task automatic run_quiet(input string what, input int budget);
    int k;
    k = 0;
    while (!(bench_q == '0 && !m_moving && m_door == 0 && !m_closing) && k < budget) begin
      drive('0, 1'b0, 1'b0);
      k++;
    end
    if (k >= budget) bound_fail(what, budget);
    drive('0, 1'b0, 1'b0);
  endtask

  // Monitor: one comparison per presented output cycle plus the motor/door exclusion.
  initial begin
    obs_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a.floor = current_floor; a.dir = current_up_ndown; a.men = motor_en;
        a.mdir = motor_up_ndown; a.door = door_open; a.clr = clear_req;
        cyc++;
        n_tests++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL cyc%0d: got floor=%0d dir=%b men=%b mdir=%b door=%b clr=%b, want floor=%0d dir=%b men=%b mdir=%b door=%b clr=%b",
                   cyc, a.floor, a.dir, a.men, a.mdir, a.door, a.clr,
                   e.floor, e.dir, e.men, e.mdir, e.door, e.clr);
        end
        n_tests++;
        if (motor_en === 1'b1 && door_open === 1'b1) begin
          n_fail++;
          $display("FAIL excl_cyc%0d: got motor_en=1 door_open=1, want not both high", cyc);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [6:0] nc;
    rst = 1'b1; queue_status = '0; queue_empty = 1'b1; next_up_ndown = 1'b1;
    model_reset();
    bench_q = '0; clr_prev = '0;

    drive('0, 1'b1, 1'b0);
    drive('0, 1'b1, 1'b0);
    repeat (3) drive('0, 1'b0, 1'b0);

    // Single call at floor 3 from reset.
    drive(7'b0001000, 1'b0, 1'b0);
    run_quiet("to_floor3", 80);

    // Reach floor 2, then a call at the idle car's own floor.
    drive(7'b0000100, 1'b0, 1'b0);
    run_quiet("to_floor2", 80);
    drive(7'b0000100, 1'b0, 1'b0);
    run_quiet("call_here", 40);

    // Floor 0, then up to 5 with floor 2 requested between floors 1 and 2.
    drive(7'b0000001, 1'b0, 1'b0);
    run_quiet("to_floor0", 80);
    drive(7'b0100000, 1'b0, 1'b0);
    k = 0;
    while (!(m_moving && m_floor == 1 && m_ticks == 1) && k < 40) begin
      drive('0, 1'b0, 1'b0); k++;
    end
    if (k >= 40) bound_fail("reach_1_2", 40);
    drive(7'b0000100, 1'b0, 1'b0);
    run_quiet("stop2_then5", 120);

    // Door open at floor 4; re-request floor 4 in dwell cycle 2.
    drive(7'b0010000, 1'b0, 1'b0);
    k = 0;
    while (!(m_door == 2) && k < 40) begin
      drive('0, 1'b0, 1'b0); k++;
    end
    if (k >= 40) bound_fail("dwell2_floor4", 40);
    drive(7'b0010000, 1'b0, 1'b0);
    run_quiet("dwell_restart", 60);

    // Floor 6, then forced upward with nothing pending.
    drive(7'b1000000, 1'b0, 1'b0);
    run_quiet("to_floor6", 80);
    repeat (6) drive('0, 1'b0, 1'b1);
    run_quiet("after_force", 20);

    // Reset in travel cycle 2 between floors 3 and 4.
    drive(7'b0000001, 1'b0, 1'b0);
    run_quiet("back_to_0", 120);
    drive(7'b1000000, 1'b0, 1'b0);
    k = 0;
    while (!(m_moving && m_floor == 3 && m_ticks == 2) && k < 60) begin
      drive('0, 1'b0, 1'b0); k++;
    end
    if (k >= 60) bound_fail("reach_3_4", 60);
    drive('0, 1'b1, 1'b0);
    repeat (3) drive('0, 1'b0, 1'b0);

    // Random calls with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      nc = '0;
      if ($urandom_range(0, 7) == 0) nc[$urandom_range(0, 6)] = 1'b1;
      if ($urandom_range(0, 31) == 0) nc[$urandom_range(0, 6)] = 1'b1;
      drive(nc, ($urandom_range(0, 599) == 0), 1'b0);
    end
    run_quiet("drain", 400);

    @(posedge clk);
    #2;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover: got %0d unchecked entries, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
